// File: rtl/serial_shift_unit_if.sv
// Bundle between the control unit and the serial shifter.
//
// Handshake: the master raises start with op/operand/shamt_ext valid; the
// shifter samples them only on an edge where it is idle (busy=0). Requests
// made while busy is high are dropped, not queued. busy stays high from the
// accepting edge through the done cycle; done is a one-cycle pulse, and
// result is valid in that cycle and holds until the next accepted start.
interface serial_shift_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand;
    logic [31:0]     shamt_ext;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand, shamt_ext,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, shamt_ext,
        output busy, done, result
    );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter: one bit position per clock.
// busy/done/result come straight from registers, so no input reaches an
// output combinationally. state_o exposes the FSM state for observation.
module serial_shift_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    serial_shift_unit_if.slave  bus_if,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [XLEN-1:0]    shifted;

    // One-bit step of the working register for the latched operation.
    always_comb begin
        shifted = work_q;
        case (op_q)
            OP_SLL:  shifted = {work_q[XLEN-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[XLEN-1:1]};
            OP_SRA:  shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: shifted = {work_q[XLEN-2:0], work_q[XLEN-1]};
        endcase
    end

    // Next-state logic: accept in IDLE, step in SHIFT, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_if.start) begin
                    work_d  = bus_if.operand;
                    count_d = bus_if.shamt_ext[SHAMT_W-1:0];
                    op_d    = bus_if.op;
                    // A zero count skips shifting entirely.
                    if (bus_if.shamt_ext[SHAMT_W-1:0] == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = shifted;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight and clears result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            count_q <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    assign bus_if.busy   = (state_q != ST_IDLE);
    assign bus_if.done   = (state_q == ST_DONE);
    assign bus_if.result = work_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed and random checks of serial_shift_unit against an arithmetic model.
module tb_serial_shift_unit;
    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         n_chk;
    int         n_fail;

    serial_shift_unit_if #(.XLEN(32)) ifc ();

    serial_shift_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_if  (ifc.slave),
        .state_o (state_dbg)
    );

    // Clock and reset generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift done at once with plain operators.
    function automatic logic [31:0] model(input logic [1:0] op_v, input logic [31:0] x,
                                          input logic [31:0] sh);
        int n;
        n = int'(sh[4:0]);
        case (op_v)
            2'b00:   return x << n;
            2'b01:   return x >> n;
            2'b10:   return 32'($signed(x) >>> n);
            default: return (n == 0) ? x : ((x << n) | (x >> (32 - n)));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // noise: 0 = start low while busy, 1 = random start pulses, 2 = start held high
    task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] opnd,
                          input logic [31:0] sh, input int noise);
        logic [31:0] exp;
        int          n;
        exp = model(op_v, opnd, sh);
        n   = int'(sh[4:0]);
        @(negedge clk);
        ifc.start     = 1'b1;
        ifc.op        = op_v;
        ifc.operand   = opnd;
        ifc.shamt_ext = sh;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (k <= n) begin
                chk($sformatf("%s busy k=%0d", tag, k), 32'(ifc.busy), 32'd1);
                chk($sformatf("%s done k=%0d", tag, k), 32'(ifc.done), (k == n) ? 32'd1 : 32'd0);
                if (k == n) chk($sformatf("%s result", tag), ifc.result, exp);
                case (noise)
                    1: ifc.start = 1'($urandom_range(0, 1));
                    2: ifc.start = 1'b1;
                    default: ifc.start = 1'b0;
                endcase
                if (noise != 0) begin
                    ifc.op        = 2'($urandom_range(0, 3));
                    ifc.operand   = $urandom;
                    ifc.shamt_ext = $urandom;
                end
            end else begin
                chk($sformatf("%s idle busy", tag), 32'(ifc.busy), 32'd0);
                chk($sformatf("%s idle done", tag), 32'(ifc.done), 32'd0);
                chk($sformatf("%s held result", tag), ifc.result, exp);
                ifc.start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a1, a2, e1, e2;
        logic [1:0]  o1, o2;
        n_chk  = 0;
        n_fail = 0;
        rst           = 1'b1;
        ifc.start     = 1'b0;
        ifc.op        = 2'b00;
        ifc.operand   = '0;
        ifc.shamt_ext = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset busy", 32'(ifc.busy), 32'd0);
        chk("reset done", 32'(ifc.done), 32'd0);
        chk("reset result", ifc.result, 32'd0);
        chk("reset state", 32'(state_dbg), 32'd0);

        // Reset mid-SHIFT aborts without a done pulse
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = 2'b00; ifc.operand = 32'hFFFF0000; ifc.shamt_ext = 32'd10;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-abort busy", 32'(ifc.busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(ifc.busy), 32'd0);
        chk("abort done", 32'(ifc.done), 32'd0);
        chk("abort result", ifc.result, 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("abort no done %0d", i), 32'(ifc.done), 32'd0);
        end

        // Directed operations
        run_op("sll31", 2'b00, 32'h00000001, 32'h0000001F, 0);
        chk("sll31 value", ifc.result, 32'h80000000);
        run_op("sra4", 2'b10, 32'h80000000, 32'd4, 0);
        chk("sra4 value", ifc.result, 32'hF8000000);
        run_op("srl4", 2'b01, 32'h80000000, 32'd4, 0);
        chk("srl4 value", ifc.result, 32'h08000000);
        run_op("zero", 2'b11, 32'hDEADBEEF, 32'h00000020, 0);
        chk("zero value", ifc.result, 32'hDEADBEEF);
        run_op("rol1", 2'b11, 32'h80000001, 32'd1, 2);
        chk("rol1 value", ifc.result, 32'h00000003);
        run_op("sra_pos", 2'b10, 32'h7FFFFFFF, 32'd31, 1);

        // Back-to-back with start held high: done after E3 and after E8
        a1 = $urandom; a2 = $urandom;
        o1 = 2'($urandom_range(0, 3)); o2 = 2'($urandom_range(0, 3));
        e1 = model(o1, a1, 32'd3);
        e2 = model(o2, a2, 32'd3);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = o1; ifc.operand = a1; ifc.shamt_ext = 32'd3;
        for (int t = 0; t <= 9; t++) begin
            @(negedge clk);
            if (t == 0) begin
                ifc.op = o2; ifc.operand = a2;
            end
            chk($sformatf("b2b done t=%0d", t), 32'(ifc.done), (t == 3 || t == 8) ? 32'd1 : 32'd0);
            chk($sformatf("b2b busy t=%0d", t), 32'(ifc.busy), (t == 4 || t == 9) ? 32'd0 : 32'd1);
            if (t == 3 || t == 4) chk($sformatf("b2b first t=%0d", t), ifc.result, e1);
            if (t == 8) begin
                chk("b2b second", ifc.result, e2);
                ifc.start = 1'b0;
            end
        end

        // Random operations with stray start pulses while busy
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), $urandom, $urandom, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
